// File: rtl/bram_fifo_ctrl.sv
// Single-clock FIFO controller that drives an external synchronous dual-port BRAM
// (writes on port A, reads on port B) and presents a valid/ready stream with a 2-entry output buffer.
`timescale 1ns/1ps
module bram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  bram_a_wr,
  output logic [ADDR_WIDTH-1:0] bram_a_addr,
  output logic [DATA_WIDTH-1:0] bram_a_data_in,
  output logic                  bram_b_wr,
  output logic [ADDR_WIDTH-1:0] bram_b_addr,
  input  logic [DATA_WIDTH-1:0] bram_b_data_out
);

  localparam int                DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            obuf_cnt_q, obuf_cnt_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;

  logic       push;
  logic       pop;
  logic       fetch;
  logic [1:0] obuf_after_pop;
  logic [2:0] pending;

  // mem_cnt only covers words written at earlier edges, so port B never
  // targets the address port A is writing this cycle.
  assign full      = (mem_cnt_q == DEPTH_CNT);
  assign in_ready  = rst_n & ~full;
  assign push      = in_valid & in_ready;
  assign out_valid = (obuf_cnt_q != 2'd0);
  assign pop       = out_valid & out_ready;

  assign obuf_after_pop = obuf_cnt_q - {1'b0, pop};
  assign pending        = {1'b0, obuf_after_pop} + {2'b00, inflight_q};
  assign fetch          = (mem_cnt_q != '0) && (pending < 3'd2);

  assign bram_a_wr      = push;
  assign bram_a_addr    = wr_ptr_q;
  assign bram_a_data_in = in_data;
  assign bram_b_wr      = 1'b0;
  assign bram_b_addr    = rd_ptr_q;

  assign out_data = head_q;
  assign count    = mem_cnt_q
                  + {{ADDR_WIDTH{1'b0}}, inflight_q}
                  + {{(ADDR_WIDTH - 1){1'b0}}, obuf_cnt_q};
  assign empty    = (count == '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_cnt_d  = mem_cnt_q;
    inflight_d = fetch;
    obuf_cnt_d = pending[1:0];
    head_d     = head_q;
    skid_d     = skid_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (fetch) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    mem_cnt_d = mem_cnt_q + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, fetch};

    if (pop && (obuf_cnt_q == 2'd2)) begin
      head_d = skid_q;
    end
    // Returning read data lands in whichever slot is next in line after the pop.
    if (inflight_q) begin
      if (obuf_after_pop == 2'd0) begin
        head_d = bram_b_data_out;
      end else begin
        skid_d = bram_b_data_out;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= 1'b0;
      obuf_cnt_q <= 2'd0;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      inflight_q <= inflight_d;
      obuf_cnt_q <= obuf_cnt_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
Single-clock FIFO controller that sits directly upstream of bram_sync_dp and drives its ports. Writes go to port A and reads come from port B. It hides the 1-cycle synchronous read latency behind a valid/ready stream interface, using a 2-entry output buffer so a continuous stream runs at full throughput. The BRAM is instantiated beside this block by the parent, with a_clk = b_clk = clk.

Parameters:
DATA_WIDTH, 32, word width; must match the paired bram_sync_dp.
ADDR_WIDTH, 4, BRAM address width; BRAM depth DEPTH = 2**ADDR_WIDTH; legal range ADDR_WIDTH >= 2.

Ports:
clk  in  1  single clock for all logic and both BRAM ports.
rst_n  in  1  asynchronous reset, active-low.
in_data  in  DATA_WIDTH  write word.
in_valid  in  1  in_data valid.
in_ready  out  1  controller can accept a word.
out_data  out  DATA_WIDTH  head word, registered.
out_valid  out  1  out_data valid.
out_ready  in  1  consumer takes out_data.
count  out  ADDR_WIDTH+1  total words held (BRAM + in-flight + output buffer).
full  out  1  BRAM region full (mem_cnt == DEPTH).
empty  out  1  count == 0.
bram_a_wr  out  1  port A write enable.
bram_a_addr  out  ADDR_WIDTH  port A address (write pointer).
bram_a_data_in  out  DATA_WIDTH  port A write data.
bram_b_wr  out  1  tied 0.
bram_b_addr  out  ADDR_WIDTH  port B address (read pointer).
bram_b_data_out  in  DATA_WIDTH  port B registered read data.

Behaviour:
- Reset (rst_n low, async): wr_ptr=0, rd_ptr=0, mem_cnt=0, inflight=0, obuf_cnt=0, out_valid=0, out_data=0, count=0, full=0, empty=1. in_ready and bram_a_wr are forced to 0 while rst_n is low.
- Reset mid-operation: all contents are discarded. The BRAM contents are not cleared, but they are unreachable.
- Push = in_valid & in_ready.
  - in_ready = !full, derived from registered mem_cnt only.
  - A pop in the same cycle never frees a slot for a push.
- Write path (combinational from push): bram_a_wr = push, bram_a_addr = wr_ptr, bram_a_data_in = in_data. On push, wr_ptr increments modulo DEPTH at the edge.
- Pop = out_valid & out_ready.
- Fetch: fetch = (mem_cnt != 0) & ((obuf_cnt + inflight - pop) < 2).
  - bram_b_addr = rd_ptr at all times.
  - On fetch, rd_ptr increments modulo DEPTH, and inflight is set to 1 for the next cycle; otherwise inflight is 0.
- Read-during-write safety: mem_cnt counts only words written at previous edges, so port B never reads the address port A is writing in the same cycle.
- mem_cnt update: mem_cnt <= mem_cnt + push - fetch. Range is 0..DEPTH.
- Output buffer: two registered entries, head and skid.
  - When inflight=1, bram_b_data_out is captured at the edge into the head if the buffer would otherwise be empty after the pop, else into the skid.
  - On pop with skid occupied, skid moves to head.
  - out_data is the head; out_valid = (obuf_cnt != 0).
  - out_data holds stable while out_valid=1 and out_ready=0.
- Latency: a word pushed in cycle t (with the FIFO empty) gives out_valid=1 with that word in cycle t+3.
- Throughput: 1 word/cycle sustained with in_valid=out_ready=1.
- Capacity: DEPTH+2 words total. count = mem_cnt + inflight + obuf_cnt.
- Boundaries:
  - Simultaneous push and pop at any level are both honoured (subject to in_ready).
  - Pointer wrap from DEPTH-1 to 0 is seamless.
  - Words are never dropped, duplicated or reordered.
  - A push while full is ignored; no BRAM write occurs.
  - out_ready with out_valid=0 has no effect.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high -> in_ready=1, out_valid=0, count=0, empty=1, bram_a_wr=0.
- Single word: push 0xA5A5_0001 in cycle t, out_ready=1 -> out_valid=1 in t+3 with out_data=0xA5A5_0001; out_valid=0 in t+4; count back to 0.
- Fill, out_ready=0: push 0..19 continuously -> 18 words accepted (0..17); in_ready=0 from the cycle after the 18th push; count=18, full=1. Then drain with out_ready=1 -> 0..17 out in order, no gaps after the first.
- Streaming wrap: in_valid=out_ready=1 for 40 cycles with incrementing data -> out_data increments by 1 every cycle after the 3-cycle latency; pointers wrap twice; count stays at 3.
- Backpressure toggling: out_ready alternates 1/0 while pushing 0x100..0x11F -> every word is delivered exactly once in order; out_data is stable whenever out_valid=1 and out_ready=0.
- Reset mid-stream: assert rst_n low asynchronously with count=7 -> count=0, out_valid=0 immediately. After release, push 0x55 -> out_data=0x55 three cycles later, with no stale words.
